act_serializer: RTL and testbench
=================================

ACT_SERIALIZER -- requirements
Module: act_serializer

Interface
REQ-001 Parameter N_ACT, default 15, number of activation words captured per frame (range 2..64).
REQ-002 Parameter DW, default 32, word width (IEEE-754 single-precision bit pattern, treated as opaque except sign bit and zero test).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port load  input  1  capture strobe; samples act_in when asserted and load_ready is high.
REQ-006 Port act_in  input  N_ACT*DW  parallel node outputs; word k occupies bits [k*DW+DW-1 : k*DW].
REQ-007 Port load_ready  output  1  high when a new frame may be captured.
REQ-008 Port out_valid  output  1  out_data/out_idx/out_last valid.
REQ-009 Port out_ready  input  1  downstream accepts when out_valid and out_ready both high (beat).
REQ-010 Port out_data  output  DW  current activation word.
REQ-011 Port out_idx  output  6  index k of out_data within the frame.
REQ-012 Port out_last  output  1  high on the final beat of a frame.

Function
REQ-013 FSM states IDLE, SEND; reset state IDLE.
REQ-014 IDLE: load_ready=1, out_valid=0; load=1 registers all N_ACT words into frame buffer, index counter set to first index to send, next state SEND.
REQ-015 SEND: load_ready=0, out_valid=1; load ignored.
REQ-016 out_data/out_idx/out_last driven from registers; no combinational path from out_ready or load to any output.
REQ-017 Beat: counter advances to next index to send; out_data updates on following edge; one beat per cycle sustainable.
REQ-018 out_valid=1 and out_data/out_idx/out_last stable while out_ready=0 (backpressure holds indefinitely).
REQ-019 out_last=1 exactly when out_idx is the last index to send in the frame; beat with out_last=1 returns FSM to IDLE, load_ready=1 on next cycle.
REQ-020 Without skipping, a frame is exactly N_ACT beats, out_idx 0..N_ACT-1 ascending; latency load-to-first-valid = 1 cycle.
REQ-021 Load in the cycle after the last beat is accepted (no idle bubble beyond the single IDLE cycle).
REQ-022 Words pass bit-exact; no arithmetic on data.

Reset
REQ-023 rst=1 at any edge: state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, load_ready=1 on next cycle; frame in flight discarded.
REQ-024 rst has priority over load and out_ready in the same cycle.
REQ-025 Frame buffer contents need not be reset.

Configuration
REQ-026 Macro ACT_SERIALIZER_ZERO_SKIP_EN defined: words whose bits [DW-2:0] are all zero (+0.0/-0.0) are not sent; out_idx carries original index; out_last marks last non-zero word.
REQ-027 With skip enabled and all words zero: frame produces one beat, idx N_ACT-1, data 0, out_last=1 (frame boundary never lost).
REQ-028 Macro undefined: every word sent per REQ-020; no skip logic synthesized.

Structure
REQ-029 Shared package act_pkg holds DW, N_ACT default, IDX_W=6, FSM state enum.
REQ-030 One sub-module act_next_idx: combinational finder returning next index to send at or after a start index and a "none left" flag (trivial increment when skip disabled).

Verification
REQ-031 Load words 0x3F800000+k, out_ready=1 -> 15 consecutive beats, idx 0..14, data matches, out_last only on idx 14.
REQ-032 Same frame, out_ready toggling 1,0,0,1 -> no beat lost/duplicated, outputs stable while stalled.
REQ-033 rst asserted at beat idx 6 -> next cycle out_valid=0, load_ready=1; new load restarts at idx 0.
REQ-034 load held high during SEND with different act_in -> ignored; transmitted frame unchanged.
REQ-035 ZERO_SKIP_EN, words k=3,7,14 non-zero (k=5 = 0x80000000) -> 3 beats idx 3,7,14, last on 14; all-zero frame -> single beat idx 14, data 0, last=1.
REQ-036 Back-to-back frames, load asserted first IDLE cycle -> second frame's first beat one cycle after load.

Source files
------------

// File: rtl/act_pkg.sv
// Shared definitions for the activation serializer: default word width,
// default frame size, output index width and the FSM state encoding.
package act_pkg;

  localparam int DW        = 32;
  localparam int N_ACT_DEF = 15;
  localparam int IDX_W     = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/act_next_idx.sv
// Combinational finder: returns the first index at or after 'start' whose
// word should be transmitted, plus a flag when no such index remains.
// Optional macro ACT_SERIALIZER_ZERO_SKIP_EN: words whose magnitude bits are
// all zero (+0.0 / -0.0) are skipped; otherwise every index is sendable and
// the finder reduces to a range check on 'start'.
module act_next_idx #(
  parameter int N_ACT = act_pkg::N_ACT_DEF,
  parameter int DW    = act_pkg::DW
) (
  input  logic [N_ACT*DW-1:0]       words,
  input  logic [act_pkg::IDX_W:0]   start,
  output logic [act_pkg::IDX_W-1:0] idx,
  output logic                      none
);
  import act_pkg::*;

  localparam int IW = IDX_W;

  // Sign bits are never inspected; fold all bits so the whole bus counts as used.
  logic unused_words;
  assign unused_words = ^words;

`ifdef ACT_SERIALIZER_ZERO_SKIP_EN
  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int k = N_ACT - 1; k >= 0; k--) begin
      if ((k >= int'(start)) && (words[k*DW +: DW-1] != '0)) begin
        idx  = IW'(k);
        none = 1'b0;
      end
    end
  end
`else
  // Every word is sent, so the next index is simply the start index.
  always_comb begin
    idx  = start[IW-1:0];
    none = (int'(start) >= N_ACT);
  end
`endif

endmodule

// File: rtl/act_serializer.sv
// Activation serializer: captures N_ACT parallel words in one cycle and
// streams them out one per beat over a valid/ready interface.
// Optional macro ACT_SERIALIZER_ZERO_SKIP_EN drops +0.0/-0.0 words from the
// stream while keeping original indices; an all-zero frame still emits a
// single terminating beat so the frame boundary is never lost.
module act_serializer #(
  parameter int N_ACT = act_pkg::N_ACT_DEF,
  parameter int DW    = act_pkg::DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [N_ACT*DW-1:0]       act_in,
  output logic                      load_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic [act_pkg::IDX_W-1:0] out_idx,
  output logic                      out_last
);
  import act_pkg::*;

  localparam int IW = IDX_W;

  state_t              state_q;
  state_t              state_d;
  logic [N_ACT*DW-1:0] frame_q;
  logic [N_ACT*DW-1:0] words_sel;
  logic [IW:0]         start0;
  logic [IW:0]         start1;
  logic [IW-1:0]       idx0;
  logic [IW-1:0]       idx1_unused;
  logic                none0;
  logic                none1;
  logic [IW-1:0]       send_idx;
  logic [DW-1:0]       send_word;
  logic                capture;
  logic                advance;

  // While idle the finders look at the incoming frame so the first word is
  // ready the cycle after load; while sending they look at the stored frame.
  assign words_sel = (state_q == IDLE) ? act_in : frame_q;
  assign start0    = (state_q == IDLE) ? '0 : ({1'b0, out_idx} + (IW+1)'(1));

  // An exhausted search only happens on an all-zero frame; fall back to the
  // final index so one terminating beat is still produced.
  assign send_idx  = none0 ? IW'(N_ACT - 1) : idx0;
  assign start1    = {1'b0, send_idx} + (IW+1)'(1);

`ifdef ACT_SERIALIZER_ZERO_SKIP_EN
  assign send_word = none0 ? '0 : words_sel[send_idx*DW +: DW];
`else
  assign send_word = words_sel[send_idx*DW +: DW];
`endif

  assign capture = (state_q == IDLE) && load;
  assign advance = (state_q == SEND) && out_ready && !out_last;

  act_next_idx #(.N_ACT(N_ACT), .DW(DW)) u_find_cur (
    .words (words_sel),
    .start (start0),
    .idx   (idx0),
    .none  (none0)
  );

  act_next_idx #(.N_ACT(N_ACT), .DW(DW)) u_find_after (
    .words (words_sel),
    .start (start1),
    .idx   (idx1_unused),
    .none  (none1)
  );

  // State register; reset returns to idle and discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake flags, which depend only on the state register.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load) state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer holds the captured words; its contents need no reset.
  always_ff @(posedge clk) begin
    if (capture) frame_q <= act_in;
  end

  // Output registers load the first word on capture and step on every non-final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (capture || advance) begin
      out_data <= send_word;
      out_idx  <= send_idx;
      out_last <= none1;
    end
  end

endmodule

// File: tb/tb_act_serializer.sv
// Self-checking bench for act_serializer: table-driven vectors for the
// nominal and backpressured frame, hand sequences for reset, load-while-busy
// and zero-skip corners, then random frames against a queue-based model.
module tb_act_serializer;

  localparam int N  = 15;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [N*DW-1:0]   act_in;
  logic              load_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [5:0]        out_idx;
  logic              out_last;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] cur [N];
  logic [DW-1:0] alt [N];
  int            exp_idx_q[$];
  logic [DW-1:0] exp_data_q[$];

  typedef struct {
    logic rdy;
    int   idx;
    logic last;
  } vec_t;
  vec_t tbl[$];

  act_serializer #(.N_ACT(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .act_in     (act_in),
    .load_ready (load_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_words(input logic [DW-1:0] w [N]);
    logic [N*DW-1:0] p;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = w[k];
    return p;
  endfunction

  // Reference model: list of (index, data) beats the frame in 'cur' must produce.
  task automatic build_expect();
    exp_idx_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < N; k++) begin
`ifdef ACT_SERIALIZER_ZERO_SKIP_EN
      if (cur[k][DW-2:0] != '0) begin
        exp_idx_q.push_back(k);
        exp_data_q.push_back(cur[k]);
      end
`else
      exp_idx_q.push_back(k);
      exp_data_q.push_back(cur[k]);
`endif
    end
    if (exp_idx_q.size() == 0) begin
      exp_idx_q.push_back(N - 1);
      exp_data_q.push_back('0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit hold);
    check_output("load_ready_before_load", load_ready, 1);
    build_expect();
    act_in = pack_words(cur);
    load   = 1'b1;
    step();
    if (hold) act_in = pack_words(alt);
    else      load   = 1'b0;
  endtask

  task automatic check_beat(input int pos);
    check_output("beat_valid", out_valid, 1);
    check_output("beat_idx",   out_idx,   exp_idx_q[pos]);
    check_output("beat_data",  out_data,  exp_data_q[pos]);
    check_output("beat_last",  out_last,  (pos == exp_idx_q.size() - 1));
  endtask

  task automatic check_idle_after(input string name);
    check_output({name, "_valid"},      out_valid,  0);
    check_output({name, "_load_ready"}, load_ready, 1);
  endtask

  // Loads 'cur', drains the frame with optional random backpressure and optional load held high.
  task automatic send_frame(input bit rand_ready, input bit hold);
    int   pos = 0;
    int   cyc = 0;
    logic v;
    do_load(hold);
    while (pos < exp_idx_q.size() && cyc < 200) begin
      check_beat(pos);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      v = out_valid;
      step();
      if (out_ready && v) pos++;
      cyc++;
    end
    load      = 1'b0;
    out_ready = 1'b0;
    if (pos < exp_idx_q.size()) check_output("frame_timeout", 0, 1);
    check_idle_after("frame_end");
  endtask

  // Applies a slice of the vector table to a freshly loaded frame.
  task automatic apply_stimulus(input int lo, input int hi);
    do_load(1'b0);
    for (int i = lo; i < hi; i++) begin
      check_output("vec_valid", out_valid, 1);
      check_output("vec_idx",   out_idx,   tbl[i].idx);
      check_output("vec_data",  out_data,  32'h3F80_0000 + tbl[i].idx);
      check_output("vec_last",  out_last,  tbl[i].last);
      out_ready = tbl[i].rdy;
      step();
    end
    out_ready = 1'b0;
    check_idle_after("vec_end");
  endtask

  initial begin
    int n_plain;
    int idx;
    int j;
    logic [3:0] pat;

    rst       = 1'b1;
    load      = 1'b0;
    out_ready = 1'b0;
    act_in    = '0;
    step();
    step();
    check_output("reset_valid",      out_valid,  0);
    check_output("reset_load_ready", load_ready, 1);
    check_output("reset_idx",        out_idx,    0);
    check_output("reset_data",       out_data,   0);
    check_output("reset_last",       out_last,   0);
    rst = 1'b0;
    step();

    // Vector table: a full-speed frame followed by a 1,0,0,1 backpressured frame.
    for (int k = 0; k < N; k++) tbl.push_back('{1'b1, k, (k == N - 1)});
    n_plain = tbl.size();
    pat = 4'b1001;
    idx = 0;
    j   = 0;
    while (idx < N) begin
      tbl.push_back('{pat[3 - (j % 4)], idx, (idx == N - 1)});
      if (pat[3 - (j % 4)]) idx++;
      j++;
    end

    for (int k = 0; k < N; k++) cur[k] = 32'h3F80_0000 + k;
    apply_stimulus(0, n_plain);
    apply_stimulus(n_plain, tbl.size());

    // Reset arriving on the idx-6 beat, with load also high, aborts the frame.
    do_load(1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_idx != 6; c++) step();
    check_output("rst_reached_idx6", out_idx, 6);
    rst  = 1'b1;
    load = 1'b1;
    step();
    rst       = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    check_output("rst_mid_valid",      out_valid,  0);
    check_output("rst_mid_load_ready", load_ready, 1);
    check_output("rst_mid_idx",        out_idx,    0);
    check_output("rst_mid_data",       out_data,   0);
    check_output("rst_mid_last",       out_last,   0);
    send_frame(1'b0, 1'b0);

    // Load held high with different data throughout a frame is ignored.
    for (int k = 0; k < N; k++) alt[k] = ~cur[k];
    send_frame(1'b1, 1'b1);

    // Sparse frame: only 3, 7, 14 carry magnitude; 5 is negative zero.
    for (int k = 0; k < N; k++) cur[k] = '0;
    cur[3]  = 32'h4040_0000;
    cur[5]  = 32'h8000_0000;
    cur[7]  = 32'hC0E0_0000;
    cur[14] = 32'h4160_0000;
    send_frame(1'b0, 1'b0);
`ifdef ACT_SERIALIZER_ZERO_SKIP_EN
    check_output("sparse_beats", exp_idx_q.size(), 3);
`else
    check_output("sparse_beats", exp_idx_q.size(), N);
`endif

    // All-zero frame, final word negative zero, sent back-to-back after the sparse one.
    for (int k = 0; k < N; k++) cur[k] = '0;
    cur[14] = 32'h8000_0000;
    send_frame(1'b0, 1'b0);

    // Random frames with a mix of zeros, negative zeros and random words.
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       cur[k] = '0;
          1:       cur[k] = 32'h8000_0000;
          default: cur[k] = $urandom;
        endcase
      end
      if (f % 7 == 3) for (int k = 0; k < N; k++) cur[k] = '0;
      send_frame(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
